ibex_div_iter: RTL

Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU. It sits directly upstream of the ALU and borrows the ALU's shared 33-bit adder through the ALU's multdiv operand and enable ports, consuming the ALU's 34-bit extended adder result. It runs a fixed-latency restoring-division sequence, one adder use per cycle, and returns the result to the EX stage with a single-cycle valid pulse.

---
 rtl/ibex_div_iter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_div_iter.sv
// ibex_div_iter
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU. It borrows the ALU's
// shared adder through the multdiv operand/enable ports. The sequence is:
// absolute value of a, absolute value of b, 32 restoring-division steps,
// sign fix-up, then a one-cycle valid pulse.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   div_en_i          request/hold; dropping it while busy aborts the operation
//   operator_i        0 DIV, 1 DIVU, 2 REM, 3 REMU (sampled at start)
//   op_a_i, op_b_i    dividend, divisor (sampled at start)
//   alu_adder_ext_i   ALU extended adder: sum = [32:1], carry = [33]
//   alu_sel_o         ALU multdiv enable (adder owned)
//   alu_operand_a_o   ALU operand A {value, carry-in}
//   alu_operand_b_o   ALU operand B {value, carry-in}
//   valid_o           one-cycle result pulse
//   result_o          registered quotient or remainder
module ibex_div_iter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        div_en_i,
   input  logic [1:0]  operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [33:0] alu_adder_ext_i,
   output logic        alu_sel_o,
   output logic [32:0] alu_operand_a_o,
   output logic [32:0] alu_operand_b_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ABS_A = 3'd1,
      ABS_B = 3'd2,
      ITER  = 3'd3,
      FIX   = 3'd4,
      DONE  = 3'd5
   } state_e;

   state_e      state_r;
   state_e      state_nxt_s;

   logic [1:0]  op_r;
   logic [31:0] a_r;        // original dividend, kept for divide-by-zero REM
   logic [31:0] a_abs_r;
   logic [31:0] b_r;        // divisor, replaced by |b| in ABS_B
   logic        sign_a_r;
   logic        sign_b_r;
   logic        b_zero_r;
   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [4:0]  cnt_r;
   logic [31:0] result_r;
   logic        valid_r;

   logic        alu_sel_s;
   logic [32:0] opa_s;
   logic [32:0] opb_s;
   logic [31:0] fix_res_s;

   // Operands are {x,1} + {y,1}, so sum bits [32:1] equal x + y + 1;
   // with y = ~v this is x - v, and the carry means "no borrow".
   logic [31:0] sum_s;
   logic        carry_s;
   logic        unused_s;
   assign sum_s    = alu_adder_ext_i[32:1];
   assign carry_s  = alu_adder_ext_i[33];
   assign unused_s = alu_adder_ext_i[0];

   logic        signed_s;
   logic        is_rem_s;
   logic        neg_a_s;
   logic        neg_b_s;
   logic        neg_quo_s;
   logic        fix_neg_s;
   logic [31:0] fix_val_s;
   logic [31:0] rsh_s;
   assign signed_s  = ~op_r[0];
   assign is_rem_s  = op_r[1];
   assign neg_a_s   = signed_s & sign_a_r;
   assign neg_b_s   = signed_s & sign_b_r;
   assign neg_quo_s = signed_s & (sign_a_r ^ sign_b_r) & ~b_zero_r;
   assign fix_val_s = is_rem_s ? rem_r : quo_r;
   assign fix_neg_s = is_rem_s ? neg_a_s : neg_quo_s;
   assign rsh_s     = {rem_r[30:0], quo_r[31]};

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a dropped enable aborts any busy state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:  if (div_en_i) state_nxt_s = ABS_A; else state_nxt_s = IDLE;
         ABS_A: if (div_en_i) state_nxt_s = ABS_B; else state_nxt_s = IDLE;
         ABS_B: if (div_en_i) state_nxt_s = ITER;  else state_nxt_s = IDLE;
         ITER: begin
            if (!div_en_i) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == 5'd31) begin
               state_nxt_s = FIX;
            end else begin
               state_nxt_s = ITER;
            end
         end
         FIX:   if (div_en_i) state_nxt_s = DONE;  else state_nxt_s = IDLE;
         DONE:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Adder ownership and operands, combinational from state
   always_comb begin
      alu_sel_s = 1'b0;
      opa_s     = 33'd0;
      opb_s     = 33'd0;
      case (state_r)
         ABS_A: begin
            alu_sel_s = 1'b1;
            if (neg_a_s) begin
               opa_s = {32'd0, 1'b1};
               opb_s = {~a_r, 1'b1};
            end else begin
               opa_s = 33'd0;
               opb_s = 33'd0;
            end
         end
         ABS_B: begin
            alu_sel_s = 1'b1;
            if (neg_b_s) begin
               opa_s = {32'd0, 1'b1};
               opb_s = {~b_r, 1'b1};
            end else begin
               opa_s = 33'd0;
               opb_s = 33'd0;
            end
         end
         ITER: begin
            alu_sel_s = 1'b1;
            opa_s     = {rsh_s, 1'b1};
            opb_s     = {~b_r, 1'b1};
         end
         FIX: begin
            alu_sel_s = 1'b1;
            opa_s     = {32'd0, 1'b1};
            opb_s     = {~fix_val_s, 1'b1};
         end
         default: begin
            alu_sel_s = 1'b0;
            opa_s     = 33'd0;
            opb_s     = 33'd0;
         end
      endcase
   end

   // Final result selection: divide-by-zero overrides the sign fix-up
   always_comb begin
      fix_res_s = 32'd0;
      if (b_zero_r) begin
         if (is_rem_s) begin
            fix_res_s = a_r;
         end else begin
            fix_res_s = 32'hFFFF_FFFF;
         end
      end else if (fix_neg_s) begin
         fix_res_s = sum_s;
      end else begin
         fix_res_s = fix_val_s;
      end
   end

   // Datapath registers and result/valid outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_r     <= 2'd0;
         a_r      <= 32'd0;
         a_abs_r  <= 32'd0;
         b_r      <= 32'd0;
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         b_zero_r <= 1'b0;
         rem_r    <= 32'd0;
         quo_r    <= 32'd0;
         cnt_r    <= 5'd0;
         result_r <= 32'd0;
         valid_r  <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (div_en_i) begin
                  op_r     <= operator_i;
                  a_r      <= op_a_i;
                  b_r      <= op_b_i;
                  sign_a_r <= op_a_i[31];
                  sign_b_r <= op_b_i[31];
                  b_zero_r <= (op_b_i == 32'd0);
               end
            end
            ABS_A: a_abs_r <= neg_a_s ? sum_s : a_r;
            ABS_B: begin
               b_r   <= neg_b_s ? sum_s : b_r;
               rem_r <= 32'd0;
               quo_r <= a_abs_r;
               cnt_r <= 5'd0;
            end
            ITER: begin
               cnt_r <= cnt_r + 5'd1;
               if (carry_s) begin
                  rem_r <= sum_s;
                  quo_r <= {quo_r[30:0], 1'b1};
               end else begin
                  rem_r <= rsh_s;
                  quo_r <= {quo_r[30:0], 1'b0};
               end
            end
            FIX: begin
               // An abort in FIX leaves the previous result untouched
               if (div_en_i) begin
                  result_r <= fix_res_s;
                  valid_r  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_sel_o       = alu_sel_s;
   assign alu_operand_a_o = opa_s;
   assign alu_operand_b_o = opb_s;
   assign valid_o         = valid_r;
   assign result_o        = result_r;

endmodule
